// File: rtl/reservation_station.sv
// reservation_station: Tomasulo reservation station feeding one functional unit.
// Ports: clock/reset_n (async active-low); issue_* write one instruction into the
// lowest free entry; cdb_* broadcast results that wake pending sources;
// fu_available/fu_done are FU handshakes; fu_* carry the dispatched instruction,
// tag and operands (fu_r2 = Vj, fu_r1 = Vk); busy_count counts occupied entries.
module reservation_station #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int TAG_W  = 3
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [DATA_W-1:0]          issue_inst,
   input  logic [TAG_W-1:0]           issue_tag,
   input  logic                       issue_qj_pend,
   input  logic [TAG_W-1:0]           issue_qj,
   input  logic [DATA_W-1:0]          issue_vj,
   input  logic                       issue_qk_pend,
   input  logic [TAG_W-1:0]           issue_qk,
   input  logic [DATA_W-1:0]          issue_vk,
   input  logic                       cdb_valid,
   input  logic [TAG_W-1:0]           cdb_tag,
   input  logic [DATA_W-1:0]          cdb_value,
   input  logic                       fu_available,
   input  logic                       fu_done,
   output logic                       fu_instruct_in,
   output logic [DATA_W-1:0]          fu_instruction,
   output logic [TAG_W-1:0]           fu_tag,
   output logic [DATA_W-1:0]          fu_r1,
   output logic [DATA_W-1:0]          fu_r2,
   output logic [$clog2(DEPTH+1)-1:0] busy_count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   typedef enum logic [1:0] {IDLE, DISPATCH, BUSY} state_t;
   state_t state, next_state;
   logic [DEPTH-1:0] valid, qj_pend, qk_pend, wake_j, wake_k;
   logic [DATA_W-1:0] inst [DEPTH];
   logic [DATA_W-1:0] vj [DEPTH];
   logic [DATA_W-1:0] vk [DEPTH];
   logic [TAG_W-1:0] tag [DEPTH];
   logic [TAG_W-1:0] qj [DEPTH];
   logic [TAG_W-1:0] qk [DEPTH];
   logic [IW-1:0] free_idx, rdy_idx;
   logic any_rdy, issue_fire, dispatch, byp_j, byp_k;
   // Downward scan leaves the lowest matching index in each selector.
   always_comb begin
      free_idx = '0;
      rdy_idx  = '0;
      any_rdy  = 1'b0;
      wake_j   = '0;
      wake_k   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) free_idx = IW'(i);
         if (valid[i] && !qj_pend[i] && !qk_pend[i]) begin
            rdy_idx = IW'(i);
            any_rdy = 1'b1;
         end
         wake_j[i] = cdb_valid && valid[i] && qj_pend[i] && qj[i] == cdb_tag;
         wake_k[i] = cdb_valid && valid[i] && qk_pend[i] && qk[i] == cdb_tag;
      end
   end
   assign issue_ready = busy_count < CW'(DEPTH);
   assign issue_fire  = issue_valid && issue_ready;
   assign dispatch    = state == IDLE && fu_available && any_rdy;
   assign byp_j       = cdb_valid && issue_qj_pend && issue_qj == cdb_tag;
   assign byp_k       = cdb_valid && issue_qk_pend && issue_qk == cdb_tag;
   // fu_available lags the strobe by one edge, so BUSY waits only on fu_done.
   always_comb begin
      next_state = state;
      next_state = (state == IDLE) ? (dispatch ? DISPATCH : IDLE) :
                   (state == DISPATCH) ? BUSY : (fu_done ? IDLE : BUSY);
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= next_state;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid          <= '0;
         qj_pend        <= '0;
         qk_pend        <= '0;
         busy_count     <= '0;
         fu_instruct_in <= 1'b0;
         fu_instruction <= '0;
         fu_tag         <= '0;
         fu_r1          <= '0;
         fu_r2          <= '0;
      end else begin
         busy_count     <= busy_count + CW'(issue_fire) - CW'(dispatch);
         fu_instruct_in <= dispatch;
         if (dispatch) begin
            fu_instruction <= inst[rdy_idx];
            fu_tag         <= tag[rdy_idx];
            fu_r1          <= vk[rdy_idx];
            fu_r2          <= vj[rdy_idx];
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (wake_j[i]) qj_pend[i] <= 1'b0;
            if (wake_k[i]) qk_pend[i] <= 1'b0;
            if (dispatch && rdy_idx == IW'(i)) valid[i] <= 1'b0;
            if (issue_fire && free_idx == IW'(i)) begin
               valid[i]   <= 1'b1;
               qj_pend[i] <= issue_qj_pend && !byp_j;
               qk_pend[i] <= issue_qk_pend && !byp_k;
            end
         end
      end
   end
   // Payload is qualified by valid/pend flags, so it needs no reset.
   always_ff @(posedge clock) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wake_j[i]) vj[i] <= cdb_value;
         if (wake_k[i]) vk[i] <= cdb_value;
         if (issue_fire && free_idx == IW'(i)) begin
            inst[i] <= issue_inst;
            tag[i]  <= issue_tag;
            qj[i]   <= issue_qj;
            qk[i]   <= issue_qk;
            vj[i]   <= byp_j ? cdb_value : issue_vj;
            vk[i]   <= byp_k ? cdb_value : issue_vk;
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed vector table plus corner-case sequences for reservation_station.
module tb_reservation_station;
   logic        clock = 1'b0, reset_n = 1'b0;
   logic        issue_valid, issue_ready, issue_qj_pend, issue_qk_pend;
   logic [15:0] issue_inst, issue_vj, issue_vk, cdb_value;
   logic [2:0]  issue_tag, issue_qj, issue_qk, cdb_tag;
   logic        cdb_valid, fu_available, fu_done, fu_instruct_in;
   logic [15:0] fu_instruction, fu_r1, fu_r2;
   logic [2:0]  fu_tag, busy_count;
   int checks = 0, errors = 0;

   reservation_station #(.DEPTH(4), .DATA_W(16), .TAG_W(3)) dut (
      .clock(clock), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
      .issue_tag(issue_tag), .issue_qj_pend(issue_qj_pend), .issue_qj(issue_qj),
      .issue_vj(issue_vj), .issue_qk_pend(issue_qk_pend), .issue_qk(issue_qk),
      .issue_vk(issue_vk), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .fu_available(fu_available), .fu_done(fu_done), .fu_instruct_in(fu_instruct_in),
      .fu_instruction(fu_instruction), .fu_tag(fu_tag), .fu_r1(fu_r1), .fu_r2(fu_r2),
      .busy_count(busy_count)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic iv; logic [15:0] inst; logic [2:0] tag;
      logic qjp; logic [2:0] qj; logic [15:0] vj;
      logic qkp; logic [2:0] qk; logic [15:0] vk;
      logic cv; logic [2:0] ctag; logic [15:0] cval;
      logic fav; logic fdone;
      logic e_str; logic [2:0] e_tag; logic [15:0] e_r1; logic [15:0] e_r2;
      logic [2:0] e_cnt; logic e_rdy;
   } vec_t;
   vec_t vec [16];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_inst = 0; issue_tag = 0;
      issue_qj_pend = 0; issue_qj = 0; issue_vj = 0;
      issue_qk_pend = 0; issue_qk = 0; issue_vk = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; fu_done = 0;
   endtask

   task automatic issue(input logic [15:0] inst, input logic [2:0] tg,
                        input logic qjp, input logic [2:0] qj, input logic [15:0] vj,
                        input logic qkp, input logic [2:0] qk, input logic [15:0] vk);
      issue_valid = 1; issue_inst = inst; issue_tag = tg;
      issue_qj_pend = qjp; issue_qj = qj; issue_vj = vj;
      issue_qk_pend = qkp; issue_qk = qk; issue_vk = vk;
      @(negedge clock);
      issue_valid = 0;
   endtask

   task automatic wait_strobe(input string name);
      int n = 0;
      while (!fu_instruct_in && n < 8) begin
         @(negedge clock);
         n++;
      end
      check(name, int'(fu_instruct_in), 1);
   endtask

   task automatic pulse_done();
      fu_done = 1;
      @(negedge clock);
      fu_done = 0;
   endtask

   task automatic no_strobe(input string name, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         check($sformatf("%s_%0d", name, c), int'(fu_instruct_in), 0);
         @(negedge clock);
      end
   endtask

   initial begin
      //          iv inst      tg qjp qj vj  qkp qk vk  cv ct cval fav fd | str tag r1 r2  cnt rdy
      vec[0]  = '{1, 16'h0010, 1, 0, 0, 7,  0, 0, 3,  0, 0, 0,  1, 0,   0, 0, 0, 0,  0, 1};
      vec[1]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   0, 0, 0, 0,  1, 1};
      vec[2]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   1, 1, 3, 7,  0, 1};
      vec[3]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,   0, 1, 3, 7,  0, 1};
      vec[4]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1,   0, 1, 3, 7,  0, 1};
      vec[5]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   0, 1, 3, 7,  0, 1};
      vec[6]  = '{1, 16'h0002, 2, 1, 5, 0,  0, 0, 4,  0, 0, 0,  1, 0,   0, 1, 3, 7,  0, 1};
      vec[7]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   0, 1, 3, 7,  1, 1};
      vec[8]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  1, 5, 20, 1, 0,   0, 1, 3, 7,  1, 1};
      vec[9]  = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   0, 1, 3, 7,  1, 1};
      vec[10] = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   1, 2, 4, 20, 0, 1};
      vec[11] = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1,   0, 2, 4, 20, 0, 1};
      vec[12] = '{1, 16'h0003, 3, 0, 0, 11, 1, 3, 0,  1, 3, 9,  1, 0,   0, 2, 4, 20, 0, 1};
      vec[13] = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   0, 2, 4, 20, 1, 1};
      vec[14] = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 0,   1, 3, 9, 11, 0, 1};
      vec[15] = '{0, 0,        0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 1,   0, 3, 9, 11, 0, 1};

      idle_inputs();
      fu_available = 0;
      @(negedge clock);
      @(negedge clock);
      check("rst_str", int'(fu_instruct_in), 0);
      check("rst_tag", int'(fu_tag), 0);
      check("rst_r1", int'(fu_r1), 0);
      check("rst_r2", int'(fu_r2), 0);
      check("rst_inst", int'(fu_instruction), 0);
      check("rst_cnt", int'(busy_count), 0);
      check("rst_rdy", int'(issue_ready), 1);
      reset_n = 1;

      // Ready issue, dependency wake-up and issue/CDB bypass, one row per cycle.
      for (int r = 0; r < 16; r++) begin
         issue_valid = vec[r].iv; issue_inst = vec[r].inst; issue_tag = vec[r].tag;
         issue_qj_pend = vec[r].qjp; issue_qj = vec[r].qj; issue_vj = vec[r].vj;
         issue_qk_pend = vec[r].qkp; issue_qk = vec[r].qk; issue_vk = vec[r].vk;
         cdb_valid = vec[r].cv; cdb_tag = vec[r].ctag; cdb_value = vec[r].cval;
         fu_available = vec[r].fav; fu_done = vec[r].fdone;
         check($sformatf("row%0d_str", r), int'(fu_instruct_in), int'(vec[r].e_str));
         check($sformatf("row%0d_tag", r), int'(fu_tag), int'(vec[r].e_tag));
         check($sformatf("row%0d_r1", r), int'(fu_r1), int'(vec[r].e_r1));
         check($sformatf("row%0d_r2", r), int'(fu_r2), int'(vec[r].e_r2));
         check($sformatf("row%0d_cnt", r), int'(busy_count), int'(vec[r].e_cnt));
         check($sformatf("row%0d_rdy", r), int'(issue_ready), int'(vec[r].e_rdy));
         @(negedge clock);
      end
      idle_inputs();

      // Back-pressure: five issues into four entries with the FU held off.
      fu_available = 0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("full_rdy%0d", i), int'(issue_ready), (i < 4) ? 1 : 0);
         issue(16'h0100 + 16'(i), 3'(i), 0, 0, 16'(i + 10), 0, 0, 16'(i + 20));
      end
      check("full_cnt", int'(busy_count), 4);
      check("full_rdy", int'(issue_ready), 0);
      no_strobe("full_hold", 2);
      fu_available = 1;
      for (int i = 0; i < 4; i++) begin
         wait_strobe($sformatf("full_strobe%0d", i));
         check($sformatf("full_tag%0d", i), int'(fu_tag), i);
         check($sformatf("full_inst%0d", i), int'(fu_instruction), 'h100 + i);
         check($sformatf("full_r2_%0d", i), int'(fu_r2), i + 10);
         check($sformatf("full_r1_%0d", i), int'(fu_r1), i + 20);
         check($sformatf("full_cnt%0d", i), int'(busy_count), 3 - i);
         @(negedge clock);
         no_strobe($sformatf("full_busy%0d", i), 3);
         pulse_done();
      end
      no_strobe("full_drop", 4);
      check("full_empty", int'(busy_count), 0);

      // Ordering: pending entry 0, pending entry 1, ready entry 2.
      fu_available = 0;
      issue(16'h0200, 5, 1, 6, 0, 0, 0, 44);
      issue(16'h0201, 6, 0, 0, 1, 1, 7, 0);
      issue(16'h0202, 7, 0, 0, 50, 0, 0, 60);
      check("ord_cnt", int'(busy_count), 3);
      fu_available = 1;
      wait_strobe("ord_first");
      check("ord_first_tag", int'(fu_tag), 7);
      check("ord_first_r2", int'(fu_r2), 50);
      check("ord_first_r1", int'(fu_r1), 60);
      cdb_valid = 1; cdb_tag = 6; cdb_value = 33;
      @(negedge clock);
      cdb_valid = 0;
      no_strobe("ord_busy", 2);
      pulse_done();
      wait_strobe("ord_second");
      check("ord_second_tag", int'(fu_tag), 5);
      check("ord_second_r2", int'(fu_r2), 33);
      check("ord_second_r1", int'(fu_r1), 44);
      check("ord_second_cnt", int'(busy_count), 1);

      // Reset while BUSY with three entries occupied.
      @(negedge clock);
      issue(16'h0300, 1, 1, 4, 0, 0, 0, 0);
      issue(16'h0301, 2, 1, 4, 0, 0, 0, 0);
      check("rb_cnt", int'(busy_count), 3);
      #2 reset_n = 0;
      #1;
      check("rb_str", int'(fu_instruct_in), 0);
      check("rb_tag", int'(fu_tag), 0);
      check("rb_r1", int'(fu_r1), 0);
      check("rb_r2", int'(fu_r2), 0);
      check("rb_inst", int'(fu_instruction), 0);
      check("rb_cnt0", int'(busy_count), 0);
      check("rb_rdy", int'(issue_ready), 1);
      @(negedge clock);
      reset_n = 1;
      pulse_done();
      cdb_valid = 1; cdb_tag = 4; cdb_value = 1;
      @(negedge clock);
      cdb_valid = 1; cdb_tag = 7;
      @(negedge clock);
      cdb_valid = 0;
      no_strobe("rb_stray", 4);
      check("rb_end_cnt", int'(busy_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station that buffers issued instructions and captures operands from the common data bus (CDB).
- When the functional unit is free, it dispatches one ready entry to it. It drives the unit's instruction/operand/tag inputs and consumes its availability and done signals.
- Sits between the issue stage and one functional unit (ADD/SUB/MUL/DIV).

Parameters:
- DEPTH, 4, number of station entries (2..8).
- DATA_W, 16, operand/instruction width.
- TAG_W, 3, producer/instruction tag width.

Ports:
- clock  in  1  single clock, posedge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  issue request this cycle.
- issue_ready  out  1  at least one free entry.
- issue_inst  in  DATA_W  instruction word; opcode in [3:0].
- issue_tag  in  TAG_W  tag forwarded with the instruction to the FU.
- issue_qj_pend  in  1  source j is waiting on a producer.
- issue_qj  in  TAG_W  producer tag for source j.
- issue_vj  in  DATA_W  source j value (used when not pending).
- issue_qk_pend, issue_qk, issue_vk  in  1/TAG_W/DATA_W  same fields for source k.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  CDB producer tag.
- cdb_value  in  DATA_W  CDB result.
- fu_available  in  1  FU can accept an instruction.
- fu_done  in  1  one-cycle FU completion pulse.
- fu_instruct_in  out  1  dispatch strobe to the FU.
- fu_instruction  out  DATA_W  dispatched instruction word.
- fu_tag  out  TAG_W  dispatched tag.
- fu_r1  out  DATA_W  FU operand R1 = Vk.
- fu_r2  out  DATA_W  FU operand R2 = Vj. FU computes R2 op R1, so SUB/DIV give Vj-Vk and Vj/Vk.
- busy_count  out  clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (async, reset_n=0):
  - all entries invalid; FSM in IDLE.
  - fu_instruct_in=0; fu_instruction, fu_tag, fu_r1, fu_r2 = 0.
  - busy_count=0; issue_ready=1.
  - The FU itself has no reset. After reset release the station dispatches only when fu_available=1.
- Entry fields: valid, inst, tag, qj_pend, qj, vj, qk_pend, qk, vk.
- Issue:
  - When issue_valid && issue_ready, the lowest-index free entry is written at the posedge.
  - issue_valid while full is ignored: no write, no error.
  - issue_ready = (busy_count < DEPTH), combinational from registered state.
- CDB capture: each posedge with cdb_valid, every valid entry whose qX_pend=1 and qX==cdb_tag loads vX=cdb_value and clears qX_pend. Both sources may capture in the same cycle.
- Issue/CDB bypass: if the issuing entry's pending source tag matches a same-cycle cdb_tag, the entry is written already resolved with cdb_value.
- Ready: entry valid && !qj_pend && !qk_pend. Selection picks the lowest-index ready entry.
- FSM:
  - IDLE: if fu_available=1 and any entry is ready, register the selected entry's inst/tag/vk/vj onto fu_*, set fu_instruct_in=1, free the entry, and go to DISPATCH.
  - DISPATCH: one cycle; fu_instruct_in returns to 0 (the strobe lasts exactly one cycle); go to BUSY. The FU samples the strobe at this edge and drops fu_available.
  - BUSY: wait for fu_done=1, then go to IDLE. fu_available is not trusted in this state because it lags the strobe by one edge.
  - A fu_done seen in IDLE or DISPATCH is ignored.
- Throughput:
  - Minimum dispatch spacing is FU latency + 2 cycles.
  - The data outputs hold the last dispatched values until the next dispatch.
- Simultaneous events:
  - Issue into the entry being freed by dispatch in the same cycle is not allowed. Free-entry selection uses pre-edge state, so a full station stays full for that cycle.
  - The CDB may wake an entry in the same cycle another entry dispatches.
  - An entry that became ready this edge is eligible from the next cycle.
- busy_count increments on issue and decrements on dispatch; both in one cycle leave it unchanged.
- Reset mid-operation (any state): returns to IDLE with all entries dropped; fu_instruct_in deasserts immediately.

Test Plan:
- Ready issue: DEPTH=4, issue ADD (inst 0x0010, tag 1, vj=7, vk=3, no pending) with fu_available=1 → fu_instruct_in pulses 2 cycles after issue; fu_r2=7, fu_r1=3, fu_tag=1. BUSY until fu_done; busy_count 1→0.
- Dependency wake: issue SUB tag 2 with qj_pend=1, qj=5, vk=4 → no dispatch. CDB (tag 5, value 20) → next IDLE cycle dispatches fu_r2=20, fu_r1=4.
- Bypass: issue with qk_pend=1, qk=3 while cdb_valid with tag 3, value 9 in the same cycle → entry written ready with vk=9; dispatched next cycle.
- Full/back-pressure: hold fu_available=0 and issue 5 ready entries → issue_ready=0 after the 4th; the 5th is dropped. Release the FU → entries dispatch in index order 0,1,2,3, each only after fu_done.
- Ordering: entry 0 pending, entry 2 ready → entry 2 dispatches first; entry 0 dispatches after its CDB wake and the next fu_done.
- Reset in BUSY: assert reset_n=0 with 3 entries occupied → outputs zero asynchronously, busy_count=0, issue_ready=1. A stray fu_done after release causes no dispatch.
